// File: rtl/booth_mul_arbiter_if.sv
// Client-side bus of the shared Booth multiplier arbiter:
// request levels, packed operands, acknowledge and result.
interface booth_mul_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   ack;
    logic [15:0]       result;
    logic [IW-1:0]     grant_id;
    logic              busy;

    modport master (
        output req, req_a, req_b,
        input  ack, result, grant_id, busy
    );

    modport slave (
        input  req, req_a, req_b,
        output ack, result, grant_id, busy
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Shares one radix-4 Booth multiplier among NREQ clients.
// Define BOOTH_ARB_PRIO_EN for fixed priority (lowest index wins).
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_mul_arbiter_if.slave   bus,
    output logic [7:0]           mul_sw,
    output logic                 mul_go,
    output logic                 mul_rst,
    input  logic [15:0]          mul_display
);
    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_LD_MD = 3'd2;
    localparam logic [2:0] S_LD_MP = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state;
    logic [7:0]    op_a;
    logic [7:0]    op_b;
    logic [7:0]    cnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic          any_req;

    assign any_req = |bus.req;

    // Multiplier is held in reset during CLR and while rst is high.
    assign mul_rst = (state == S_CLR) | rst;

`ifdef BOOTH_ARB_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Fixed priority: lowest requesting index wins.
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                win = IW'(k);
            end
        end
    end
`else
    // Round robin: search starts just after the last grantee.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                win   = IW'(idx);
                found = 1'b1;
            end
        end
    end
`endif

    // Job sequencer: grant, clear, load both operands, wait, return.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_a         <= '0;
            op_b         <= '0;
            cnt          <= '0;
            ptr          <= IW'(NREQ - 1);
            mul_sw       <= '0;
            mul_go       <= 1'b0;
            bus.ack      <= '0;
            bus.result   <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
        end else begin
            bus.ack <= '0;
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        op_a         <= bus.req_a[8*int'(win) +: 8];
                        op_b         <= bus.req_b[8*int'(win) +: 8];
                        bus.grant_id <= win;
                        bus.busy     <= 1'b1;
                        mul_sw       <= '0;
                        mul_go       <= 1'b0;
                        state        <= S_CLR;
                    end
                end
                S_CLR: begin
                    mul_sw <= op_a;
                    mul_go <= 1'b1;
                    state  <= S_LD_MD;
                end
                S_LD_MD: begin
                    mul_sw <= op_b;
                    mul_go <= 1'b1;
                    state  <= S_LD_MP;
                end
                S_LD_MP: begin
                    mul_go <= 1'b0;
                    cnt    <= 8'(MUL_LAT);
                    state  <= S_RUN;
                end
                S_RUN: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.result <= mul_display;
                    bus.ack    <= ONE << bus.grant_id;
                    ptr        <= bus.grant_id;
                    bus.busy   <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized bench for booth_mul_arbiter with a job-level
// reference model and a stand-in Booth multiplier.
module tb_booth_mul_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 8;
    localparam int IW   = $clog2(NREQ);

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mul_sw;
    logic        mul_go;
    logic        mul_rst;
    logic [15:0] mul_display;

    booth_mul_arbiter_if #(.NREQ(NREQ)) bus ();

    booth_mul_arbiter #(
        .NREQ    (NREQ),
        .MUL_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mul_sw      (mul_sw),
        .mul_go      (mul_go),
        .mul_rst     (mul_rst),
        .mul_display (mul_display)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: first go sample is the multiplicand,
    // second is the multiplier; display is their signed product.
    logic signed [7:0]  m_md;
    logic signed [7:0]  m_mp;
    logic signed [15:0] m_prod;
    int                 m_gcnt;

    assign m_prod      = m_md * m_mp;
    assign mul_display = m_prod;

    always @(posedge clk) begin
        if (mul_rst) begin
            m_md   <= '0;
            m_mp   <= '0;
            m_gcnt <= 0;
        end else if (mul_go) begin
            if (m_gcnt == 0) m_md <= mul_sw;
            else             m_mp <= mul_sw;
            m_gcnt <= m_gcnt + 1;
        end
    end

    int nerr = 0;
    int nchk = 0;

    logic [NREQ-1:0] mask;
    logic [7:0]      a [NREQ];
    logic [7:0]      b [NREQ];
    int              ptr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
`ifdef BOOTH_ARB_PRIO_EN
        for (int i = 0; i < NREQ; i++)
            if (m[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[8*i +: 8] = a[i];
            bus.req_b[8*i +: 8] = b[i];
        end
        bus.req = mask;
    endtask

    // Called #1 after an edge with the DUT idle and mask != 0.
    task automatic run_job(input bit drop, output int w);
        logic [7:0]  pa;
        logic [7:0]  pb;
        int          pr;
        logic [15:0] ex;
        int          n;
        w  = pick(mask, ptr);
        pa = a[w];
        pb = b[w];
        pr = $signed(pa) * $signed(pb);
        ex = pr[15:0];
        @(posedge clk); #1;
        chk("grant_busy", 32'(bus.busy), 1);
        chk("grant_id", 32'(bus.grant_id), 32'(w));
        chk("clr_rst", 32'(mul_rst), 1);
        chk("clr_go", 32'(mul_go), 0);
        chk("clr_sw", 32'(mul_sw), 0);
        a[w] = 8'($urandom);
        b[w] = 8'($urandom);
        if (drop) mask[w] = 1'b0;
        drive();
        @(posedge clk); #1;
        chk("ldmd_sw", 32'(mul_sw), 32'(pa));
        chk("ldmd_go", 32'(mul_go), 1);
        chk("ldmd_rst", 32'(mul_rst), 0);
        @(posedge clk); #1;
        chk("ldmp_sw", 32'(mul_sw), 32'(pb));
        chk("ldmp_go", 32'(mul_go), 1);
        @(posedge clk); #1;
        chk("run_go", 32'(mul_go), 0);
        n = 0;
        while (bus.ack == '0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_latency", 32'(n), 32'(LAT + 1));
        chk("ack_onehot", 32'(bus.ack), 32'(1 << w));
        chk("result", 32'(bus.result), 32'(ex));
        chk("done_busy", 32'(bus.busy), 0);
        ptr = w;
    endtask

    initial begin
        int w;
        int gap;
        rst  = 1'b1;
        mask = '0;
        ptr  = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_gid", 32'(bus.grant_id), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sw", 32'(mul_sw), 0);
        chk("rst_go", 32'(mul_go), 0);
        chk("rst_mulrst", 32'(mul_rst), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_mulrst", 32'(mul_rst), 0);

        a[0] = 8'd5; b[0] = 8'd3; mask = NREQ'(1);
        drive();
        run_job(1'b1, w);
        chk("res_5x3", 32'(bus.result), 32'h000F);

        a[0] = 8'hFC; b[0] = 8'd3; mask = NREQ'(1);
        drive();
        run_job(1'b1, w);
        chk("res_m4x3", 32'(bus.result), 32'hFFF4);

        a[0] = 8'h80; b[0] = 8'h80; mask = NREQ'(1);
        drive();
        run_job(1'b1, w);
        chk("res_m128sq", 32'(bus.result), 32'h4000);

        // Reset in the middle of a job drops it silently.
        a[2] = 8'd7; b[2] = 8'd9; mask = NREQ'(4);
        drive();
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_ack", 32'(bus.ack), 0);
        chk("mid_rst_result", 32'(bus.result), 0);
        chk("mid_rst_mulrst", 32'(mul_rst), 1);
        rst  = 1'b0;
        mask = '0;
        drive();
        ptr = NREQ - 1;
        repeat (LAT + 6) begin
            @(posedge clk); #1;
            chk("post_rst_ack", 32'(bus.ack), 0);
        end

        // All clients contend and keep re-requesting.
        for (int i = 0; i < NREQ; i++) begin
            a[i] = 8'($urandom);
            b[i] = 8'($urandom);
        end
        mask = '1;
        drive();
        for (int j = 0; j < NREQ + 1; j++) run_job(1'b0, w);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!mask[i]) begin
                    a[i] = 8'($urandom);
                    b[i] = 8'($urandom);
                end
            end
            if (mask == '0) begin
                drive();
                gap = $urandom_range(0, 3);
                repeat (gap) begin
                    @(posedge clk); #1;
                    chk("gap_ack", 32'(bus.ack), 0);
                    chk("gap_busy", 32'(bus.busy), 0);
                end
                mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            end
            drive();
            run_job(1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 1) == 1) mask[w] = 1'b0;
            mask = mask | NREQ'($urandom_range(0, (1 << NREQ) - 1)
                               & $urandom_range(0, (1 << NREQ) - 1));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
